// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : unified_mem_arbiter
// Brief  : Shares one single-port sync memory between fetch and data ports.
// Rev    : 1.0
// ============================================================================
module unified_mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 30
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [31:0]   if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [31:0]   if_rdata_o,
  input  logic          d_req_i,
  input  logic [31:0]   d_addr_i,
  input  logic [3:0]    d_wsel_byte_i,
  input  logic [31:0]   d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [31:0]   d_rdata_o,
  output logic          mem_ena_o,
  output logic          mem_read_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [3:0]    mem_wsel_byte_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESP_IF = 2'd1,
    ST_RESP_D  = 2'd2
  } resp_state_e;

  resp_state_e   state_q, state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          if_rvalid_q, d_rvalid_q;
  logic          starved;
  logic          gnt_if, gnt_d;

  generate
    if (STARVE_MAX != 0) begin : g_starve
      assign starved = (starve_cnt_q == CW'(STARVE_MAX));
    end else begin : g_strict
      assign starved = 1'b0;
    end
  endgenerate

  // Address bits outside the word-address window are decoded elsewhere.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr_i[1:0], d_addr_i[1:0]};

  generate
    if (AW < 30) begin : g_upper_unused
      logic unused_addr_msbs;
      assign unused_addr_msbs = ^{if_addr_i[31:AW+2], d_addr_i[31:AW+2]};
    end
  endgenerate

  always_comb begin
    gnt_if          = !rst_i && if_req_i && (!d_req_i || starved);
    gnt_d           = !rst_i && d_req_i && !gnt_if;
    mem_ena_o       = 1'b0;
    mem_read_o      = 1'b0;
    mem_addr_o      = '0;
    mem_wsel_byte_o = 4'b0000;
    mem_wdata_o     = 32'h0;
    if (gnt_if) begin
      mem_ena_o  = 1'b1;
      mem_read_o = 1'b1;
      mem_addr_o = if_addr_i[AW+1:2];
    end else if (gnt_d) begin
      mem_ena_o       = 1'b1;
      mem_read_o      = (d_wsel_byte_i == 4'b0000);
      mem_addr_o      = d_addr_i[AW+1:2];
      mem_wsel_byte_o = d_wsel_byte_i;
      mem_wdata_o     = d_wdata_i;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req_i || gnt_if) begin
      starve_cnt_d = '0;
    end else if (gnt_d && (starve_cnt_q != CW'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  // Writes carry no response, so only read grants claim the return slot.
  always_comb begin
    state_d = ST_IDLE;
    if (gnt_if) begin
      state_d = ST_RESP_IF;
    end else if (gnt_d && (d_wsel_byte_i == 4'b0000)) begin
      state_d = ST_RESP_D;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      if_rvalid_q  <= (state_d == ST_RESP_IF);
      d_rvalid_q   <= (state_d == ST_RESP_D);
    end
  end

  assign if_gnt_o    = gnt_if;
  assign d_gnt_o     = gnt_d;
  assign if_rvalid_o = if_rvalid_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign if_rdata_o  = mem_rdata_i;
  assign d_rdata_o   = mem_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_unified_mem_arbiter
// Brief  : Directed scoreboard bench for unified_mem_arbiter.
// Rev    : 1.0
// ============================================================================
module tb_unified_mem_arbiter;

  localparam int G_NONE = 0;
  localparam int G_IF   = 1;
  localparam int G_D    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;

  logic        if_req = 1'b0, d_req = 1'b0;
  logic [31:0] if_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
  logic [3:0]  d_wsel = 4'h0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_ena, mem_read;
  logic [29:0] mem_addr;
  logic [3:0]  mem_wsel;
  logic [31:0] mem_wdata, mem_rdata;

  logic        if_req1 = 1'b0, d_req1 = 1'b0;
  logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1;
  logic [31:0] if_rdata1, d_rdata1;
  logic        mem_ena1, mem_read1;
  logic [29:0] mem_addr1;
  logic [3:0]  mem_wsel1;
  logic [31:0] mem_wdata1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        is_if;
    logic [31:0] data;
    int          cycle;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] mem [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  unified_mem_arbiter #(.STARVE_MAX(4), .AW(30)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_addr_i(d_addr), .d_wsel_byte_i(d_wsel), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_ena_o(mem_ena), .mem_read_o(mem_read), .mem_addr_o(mem_addr),
    .mem_wsel_byte_o(mem_wsel), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  unified_mem_arbiter #(.STARVE_MAX(0), .AW(30)) dut_strict (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req1), .if_addr_i(32'h0000_0100), .if_gnt_o(if_gnt1),
    .if_rvalid_o(if_rvalid1), .if_rdata_o(if_rdata1),
    .d_req_i(d_req1), .d_addr_i(32'h0000_0200), .d_wsel_byte_i(4'h0), .d_wdata_i(32'h0),
    .d_gnt_o(d_gnt1), .d_rvalid_o(d_rvalid1), .d_rdata_o(d_rdata1),
    .mem_ena_o(mem_ena1), .mem_read_o(mem_read1), .mem_addr_o(mem_addr1),
    .mem_wsel_byte_o(mem_wsel1), .mem_wdata_o(mem_wdata1), .mem_rdata_i(32'h0)
  );

  // Behavioural single-port memory, 1-cycle read latency, word i = CAFE_<i>.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {16'hCAFE, 8'h00, i[7:0]};
    mem_rdata = 32'h0;
  end

  always @(posedge clk) begin
    if (mem_ena) begin
      for (int b = 0; b < 4; b++)
        if (mem_wsel[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_read) mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every rvalid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (if_rvalid || d_rvalid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got if=%0b d=%0b, expected none (t=%0t)",
                 if_rvalid, d_rvalid, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rvalid_port", {30'h0, if_rvalid, d_rvalid}, e.is_if ? 32'h2 : 32'h1);
        check("rvalid_cycle", cyc, e.cycle);
        check("rdata", e.is_if ? if_rdata : d_rdata, e.data);
      end
    end
  end

  // One cycle: drive requests, check grant and memory drive, queue read responses.
  task automatic step(input logic ir, input logic [31:0] ia,
                      input logic dr, input logic [31:0] da,
                      input logic [3:0] ws, input logic [31:0] wd,
                      input int exp_g, input logic [31:0] exp_rd);
    @(posedge clk);
    #1;
    if_req = ir; if_addr = ia; d_req = dr; d_addr = da; d_wsel = ws; d_wdata = wd;
    @(negedge clk);
    check("if_gnt", {31'h0, if_gnt}, (exp_g == G_IF) ? 32'h1 : 32'h0);
    check("d_gnt",  {31'h0, d_gnt},  (exp_g == G_D)  ? 32'h1 : 32'h0);
    check("mem_ena", {31'h0, mem_ena}, (exp_g != G_NONE) ? 32'h1 : 32'h0);
    if (exp_g == G_IF) begin
      check("mem_addr_if", {2'b0, mem_addr}, {2'b0, ia[31:2]});
      check("mem_read_if", {31'h0, mem_read}, 32'h1);
      check("mem_wsel_if", {28'h0, mem_wsel}, 32'h0);
      sb_q.push_back('{is_if: 1'b1, data: exp_rd, cycle: cyc + 1});
    end else if (exp_g == G_D) begin
      check("mem_addr_d", {2'b0, mem_addr}, {2'b0, da[31:2]});
      check("mem_read_d", {31'h0, mem_read}, (ws == 4'h0) ? 32'h1 : 32'h0);
      check("mem_wsel_d", {28'h0, mem_wsel}, {28'h0, ws});
      check("mem_wdata_d", mem_wdata, wd);
      if (ws == 4'h0) sb_q.push_back('{is_if: 1'b0, data: exp_rd, cycle: cyc + 1});
    end
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, G_NONE, 32'h0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_if_gnt"},    {31'h0, if_gnt},    32'h0);
    check({tag, "_d_gnt"},     {31'h0, d_gnt},     32'h0);
    check({tag, "_mem_ena"},   {31'h0, mem_ena},   32'h0);
    check({tag, "_if_rvalid"}, {31'h0, if_rvalid}, 32'h0);
    check({tag, "_d_rvalid"},  {31'h0, d_rvalid},  32'h0);
    check({tag, "_strict_ena"}, {31'h0, mem_ena1}, 32'h0);
  endtask

  initial begin
    if_req = 1'b1; d_req = 1'b1; if_addr = 32'h10; d_addr = 32'h20;
    #2;
    check_quiet("reset");
    repeat (2) @(posedge clk);
    #1;
    if_req = 1'b0; d_req = 1'b0;
    rst = 1'b0;

    // Lone fetch, then misaligned fetch to the same word.
    step(1'b1, 32'h0000_0010, 1'b0, 32'h0, 4'h0, 32'h0, G_IF, 32'hCAFE_0004);
    step(1'b1, 32'h0000_0013, 1'b0, 32'h0, 4'h0, 32'h0, G_IF, 32'hCAFE_0004);
    idle();

    // Partial write, then read back the merged word.
    step(1'b0, 32'h0, 1'b1, 32'h4000_0008, 4'b0011, 32'hA5A5_1234, G_D, 32'h0);
    idle();
    step(1'b0, 32'h0, 1'b1, 32'h4000_0008, 4'b0000, 32'h0, G_D, 32'hCAFE_1234);

    // Continuous contention: D,D,D,D,IF repeating.
    for (int k = 0; k < 10; k++)
      step(1'b1, 32'h20, 1'b1, 32'h30, 4'h0, 32'h0,
           ((k % 5) == 4) ? G_IF : G_D, ((k % 5) == 4) ? 32'hCAFE_0008 : 32'hCAFE_000C);

    // Dropping the fetch request clears the starvation count.
    for (int k = 0; k < 3; k++)
      step(1'b1, 32'h20, 1'b1, 32'h30, 4'h0, 32'h0, G_D, 32'hCAFE_000C);
    step(1'b0, 32'h0, 1'b1, 32'h30, 4'h0, 32'h0, G_D, 32'hCAFE_000C);
    for (int k = 0; k < 4; k++)
      step(1'b1, 32'h20, 1'b1, 32'h30, 4'h0, 32'h0, G_D, 32'hCAFE_000C);
    step(1'b1, 32'h20, 1'b1, 32'h30, 4'h0, 32'h0, G_IF, 32'hCAFE_0008);

    // Back-to-back reads on different ports.
    step(1'b0, 32'h0, 1'b1, 32'h44, 4'h0, 32'h0, G_D, 32'hCAFE_0011);
    step(1'b1, 32'h48, 1'b0, 32'h0, 4'h0, 32'h0, G_IF, 32'hCAFE_0012);
    idle();
    idle();

    // Reset asserted while both ports are requesting.
    @(posedge clk);
    #1;
    if_req = 1'b1; d_req = 1'b1; if_addr = 32'h50; d_addr = 32'h54; d_wsel = 4'h0;
    #1;
    check("pre_reset_d_gnt", {31'h0, d_gnt}, 32'h1);
    rst = 1'b1;
    #1;
    check_quiet("midreset");
    repeat (2) @(posedge clk);
    #1;
    if_req = 1'b0; d_req = 1'b0;
    rst = 1'b0;
    idle();
    idle();

    // Strict data priority instance.
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if_req1 = 1'b1; d_req1 = 1'b1;
      @(negedge clk);
      check("strict_if_gnt", {31'h0, if_gnt1}, 32'h0);
      check("strict_d_gnt",  {31'h0, d_gnt1},  32'h1);
    end
    @(posedge clk);
    #1;
    d_req1 = 1'b0;
    @(negedge clk);
    check("strict_if_gnt_after_drop", {31'h0, if_gnt1}, 32'h1);
    check("strict_d_gnt_after_drop",  {31'h0, d_gnt1},  32'h0);
    @(posedge clk);
    #1;
    if_req1 = 1'b0;
    idle();

    check("scoreboard_drained", sb_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
